// File: rtl/wb_macro_decoder.sv
// Wishbone address decoder and response mux between the management wishbone and
// NUM_SLV user macros; every access completes, with ERR_DATA on miss or timeout.
module wb_macro_decoder #(
  parameter int          NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          SLV_SHIFT = 16,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [NUM_SLV-1:0]      active_i,
  output logic [NUM_SLV-1:0]      m_cyc_o,
  output logic [NUM_SLV-1:0]      m_stb_o,
  output logic                    m_we_o,
  output logic [3:0]              m_sel_o,
  output logic [31:0]             m_adr_o,
  output logic [31:0]             m_dat_o,
  input  logic [NUM_SLV-1:0]      m_ack_i,
  input  logic [32*NUM_SLV-1:0]   m_dat_i,
  output logic                    timeout_o
);

  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int HI_LSB = SLV_SHIFT + IDX_W;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [9:0]         cnt;
  logic [31:0]        rdata_q;

  logic [IDX_W-1:0]   dec_idx;
  logic               dec_hit;
  logic [NUM_SLV-1:0] dec_onehot;
  logic               slv_ack;
  logic [31:0]        slv_dat;

  assign dec_idx = wbs_adr_i[SLV_SHIFT +: IDX_W];

  // Slot comparisons are done by loop so an out-of-range index simply matches nothing.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec_hit    = 1'b0;
    dec_onehot = '0;
    slv_ack    = 1'b0;
    slv_dat    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if ((wbs_adr_i >> HI_LSB) == (BASE_ADDR >> HI_LSB) && dec_idx == IDX_W'(i)) begin
        dec_hit       = active_i[i];
        dec_onehot[i] = 1'b1;
      end
      if (idx_q == IDX_W'(i)) begin
        slv_ack = m_ack_i[i];
        slv_dat = m_dat_i[32*i +: 32];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      idx_q     <= '0;
      cnt       <= '0;
      rdata_q   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o   <= '0;
      m_stb_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      timeout_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        IDLE: begin
          if (wbs_cyc_i && wbs_stb_i) begin
            if (dec_hit) begin
              idx_q   <= dec_idx;
              m_adr_o <= wbs_adr_i;
              m_dat_o <= wbs_dat_i;
              m_we_o  <= wbs_we_i;
              m_sel_o <= wbs_sel_i;
              m_cyc_o <= dec_onehot;
              m_stb_o <= dec_onehot;
              cnt     <= '0;
              state   <= REQ;
            end else begin
              rdata_q <= ERR_DATA;
              state   <= RESP;
            end
          end
        end
        REQ: begin
          if (!wbs_cyc_i) begin
            m_cyc_o <= '0;
            m_stb_o <= '0;
            state   <= IDLE;
          end else if (slv_ack) begin
            rdata_q <= slv_dat;
            m_cyc_o <= '0;
            m_stb_o <= '0;
            state   <= RESP;
          end else if (cnt == 10'(TIMEOUT)) begin
            rdata_q   <= ERR_DATA;
            timeout_o <= 1'b1;
            m_cyc_o   <= '0;
            m_stb_o   <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        RESP: begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= rdata_q;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
